// File: rtl/booth_pkg.sv
// booth_pkg: state encoding and default sizing shared by the Booth multiplier control slice.
package booth_pkg;

  localparam int BOOTH_N_BITS      = 16;
  localparam int BOOTH_COUNT_WIDTH = 5;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_M = 3'd1,
    S_LOAD_Q = 3'd2,
    S_EVAL   = 3'd3,
    S_ARITH  = 3'd4,
    S_SHIFT  = 3'd5,
    S_DONE   = 3'd6
  } state_t;

endpackage

// File: rtl/booth_ctrl_if.sv
// booth_ctrl_if: start/done handshake, datapath status and datapath strobes of the Booth controller.
// The abort input exists only when BOOTH_CTRL_ABORT_EN is defined.
interface booth_ctrl_if;

  logic start;
  logic q0;
  logic qm1;
  logic count_zero;
`ifdef BOOTH_CTRL_ABORT_EN
  logic abort;
`endif
  logic ld_m;
  logic ld_q;
  logic clr_a;
  logic clr_qm1;
  logic count_en;
  logic ld_a;
  logic sel_sub;
  logic sft;
  logic decr;
  logic busy;
  logic done;

  // master is the controller; slave is the host plus datapath side
  modport master (
    input  start, q0, qm1, count_zero,
`ifdef BOOTH_CTRL_ABORT_EN
    input  abort,
`endif
    output ld_m, ld_q, clr_a, clr_qm1, count_en, ld_a, sel_sub, sft, decr, busy, done
  );

  modport slave (
    output start, q0, qm1, count_zero,
`ifdef BOOTH_CTRL_ABORT_EN
    output abort,
`endif
    input  ld_m, ld_q, clr_a, clr_qm1, count_en, ld_a, sel_sub, sft, decr, busy, done
  );

endinterface

// File: rtl/booth_ctrl.sv
// booth_ctrl: Moore control FSM sequencing load, add/sub and shift steps of a radix-2 Booth multiplier.
// Define BOOTH_CTRL_ABORT_EN to add an abort input that returns any active operation to IDLE.
module booth_ctrl
  import booth_pkg::*;
#(
  parameter int N_BITS      = BOOTH_N_BITS,
  parameter int COUNT_WIDTH = BOOTH_COUNT_WIDTH
) (
  input logic          clk,
  input logic          reset_n,
  booth_ctrl_if.master bus
);

  if ((1 << COUNT_WIDTH) <= N_BITS) begin : g_bad_cfg
    $error("booth_ctrl: COUNT_WIDTH cannot hold N_BITS");
  end

  state_t state;
  state_t state_nxt;
  logic   abort_req;

`ifdef BOOTH_CTRL_ABORT_EN
  assign abort_req = bus.abort && (state != S_IDLE);
`else
  assign abort_req = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt    = S_IDLE;
    bus.ld_m     = 1'b0;
    bus.ld_q     = 1'b0;
    bus.clr_a    = 1'b0;
    bus.clr_qm1  = 1'b0;
    bus.count_en = 1'b0;
    bus.ld_a     = 1'b0;
    bus.sel_sub  = 1'b0;
    bus.sft      = 1'b0;
    bus.decr     = 1'b0;
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    case (state)
      S_IDLE:   state_nxt = bus.start ? S_LOAD_M : S_IDLE;
      S_LOAD_M: begin
        bus.ld_m  = 1'b1;
        bus.busy  = 1'b1;
        state_nxt = S_LOAD_Q;
      end
      S_LOAD_Q: begin
        bus.ld_q     = 1'b1;
        bus.clr_a    = 1'b1;
        bus.clr_qm1  = 1'b1;
        bus.count_en = 1'b1;
        bus.busy     = 1'b1;
        state_nxt    = S_EVAL;
      end
      S_EVAL: begin
        bus.busy = 1'b1;
        if (bus.count_zero)         state_nxt = S_DONE;
        else if (bus.q0 ^ bus.qm1) state_nxt = S_ARITH;
        else                        state_nxt = S_SHIFT;
      end
      // Q and Q-1 are untouched between EVAL and ARITH, so the pair is still valid here
      S_ARITH: begin
        bus.ld_a    = 1'b1;
        bus.sel_sub = bus.q0 & ~bus.qm1;
        bus.busy    = 1'b1;
        state_nxt   = S_SHIFT;
      end
      S_SHIFT: begin
        bus.sft   = 1'b1;
        bus.decr  = 1'b1;
        bus.busy  = 1'b1;
        state_nxt = S_EVAL;
      end
      S_DONE: begin
        bus.done  = 1'b1;
        state_nxt = bus.start ? S_DONE : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    // An abort cancels every datapath action except clearing A and Q-1
    if (abort_req) begin
      state_nxt    = S_IDLE;
      bus.ld_m     = 1'b0;
      bus.ld_q     = 1'b0;
      bus.count_en = 1'b0;
      bus.ld_a     = 1'b0;
      bus.sel_sub  = 1'b0;
      bus.sft      = 1'b0;
      bus.decr     = 1'b0;
      bus.done     = 1'b0;
      bus.clr_a    = 1'b1;
      bus.clr_qm1  = 1'b1;
    end
  end

endmodule

// File: tb/tb_booth_ctrl.sv
// tb_booth_ctrl: booth_ctrl driving a behavioural Booth datapath; a monitor scores products and cycle counts.
module tb_booth_ctrl;

  localparam int N  = 16;
  localparam int CW = 5;

  typedef struct {
    logic [2*N-1:0] prod;
    int             lat;
    int             k;
  } exp_t;

  logic clk = 1'b0;
  logic clk_en = 1'b0;
  logic reset_n = 1'b1;

  booth_ctrl_if bif ();

  booth_ctrl #(.N_BITS(N), .COUNT_WIDTH(CW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bif)
  );

  always #5 clk = clk_en ? ~clk : clk;

  // behavioural datapath: A carries one guard bit so that M = -2^(N-1) multiplies correctly
  logic signed [N:0] a_r;
  logic [N-1:0]      q_r;
  logic [N-1:0]      m_r;
  logic              qm1_r;
  logic [CW-1:0]     cnt_r;
  logic [N-1:0]      din_m;
  logic [N-1:0]      din_q;
  logic signed [N:0] m_ext;

  assign m_ext          = {m_r[N-1], m_r};
  assign bif.q0         = q_r[0];
  assign bif.qm1        = qm1_r;
  assign bif.count_zero = (cnt_r == '0);

  always @(posedge clk) begin
    if (bif.ld_m)     m_r   <= din_m;
    if (bif.ld_q)     q_r   <= din_q;
    if (bif.clr_a)    a_r   <= '0;
    if (bif.clr_qm1)  qm1_r <= 1'b0;
    if (bif.count_en) cnt_r <= CW'(N);
    if (bif.ld_a)     a_r   <= bif.sel_sub ? a_r - m_ext : a_r + m_ext;
    if (bif.sft)      {a_r, q_r, qm1_r} <= {a_r[N], a_r, q_r};
    if (bif.decr)     cnt_r <= cnt_r - 1'b1;
  end

  wire [10:0] outs = {bif.ld_m, bif.ld_q, bif.clr_a, bif.clr_qm1, bif.count_en, bif.ld_a,
                      bif.sel_sub, bif.sft, bif.decr, bif.busy, bif.done};

  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  // monitor: per-operation cycle counters, scored when done rises
  int   busy_cnt = 0;
  int   lda_cnt = 0;
  int   decr_cnt = 0;
  int   overlap = 0;
  logic done_q = 1'b0;
  exp_t e;

  always @(negedge clk) begin
    if (!reset_n) begin
      busy_cnt = 0; lda_cnt = 0; decr_cnt = 0; done_q = 1'b0;
    end else begin
      if (bif.busy) busy_cnt++;
      if (bif.ld_a) lda_cnt++;
      if (bif.decr) decr_cnt++;
      if (bif.ld_a && bif.sft) overlap++;
      if (bif.count_en && bif.decr) overlap++;
      if (bif.done && !done_q) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("product", 64'({a_r[N-1:0], q_r}), 64'(e.prod));
          chk("latency", 64'(busy_cnt), 64'(e.lat));
          chk("arith_iters", 64'(lda_cnt), 64'(e.k));
          chk("shift_iters", 64'(decr_cnt), 64'(N));
        end
        busy_cnt = 0; lda_cnt = 0; decr_cnt = 0;
      end else if (!bif.busy && !bif.done) begin
        busy_cnt = 0; lda_cnt = 0; decr_cnt = 0;
      end
      done_q = bif.done;
    end
  end

  task automatic wait_done();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bif.done) break;
    end
    if (!bif.done) chk("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_op(input logic [N-1:0] m, input logic [N-1:0] q, input logic [2*N-1:0] prod,
                        input int lat, input int k, input bit hold);
    exp_t x;
    x.prod = prod; x.lat = lat; x.k = k;
    sb.push_back(x);
    din_m = m; din_q = q;
    @(negedge clk); bif.start = 1'b1;
    @(negedge clk); if (!hold) bif.start = 1'b0;
    wait_done();
  endtask

  initial begin
    int sft_seen;
    int done_seen;
    bif.start = 1'b0;
`ifdef BOOTH_CTRL_ABORT_EN
    bif.abort = 1'b0;
`endif
    din_m = '0; din_q = '0;

    // asynchronous reset with the clock stopped
    #5 reset_n = 1'b0;
    #5 chk("reset_outs", 64'(outs), 64'd0);
    clk_en = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("idle_no_start", 64'(outs), 64'd0);
    end

    run_op(16'd5, 16'd0, 32'h0000_0000, 35, 0, 1'b0);
    @(negedge clk);
    run_op(16'd7, 16'hFFFD, 32'hFFFF_FFEB, 38, 3, 1'b0);
    @(negedge clk);

    // done must stay up while start is held, and drop one edge after start falls
    run_op(16'h8000, 16'h8000, 32'h4000_0000, 36, 1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("done_held", 64'(bif.done), 64'd1);
    end
    bif.start = 1'b0;
    @(posedge clk); #1;
    chk("idle_after_release", 64'(outs), 64'd0);

    // reset during the fifth SHIFT discards the operation
    din_m = 16'd9; din_q = 16'h1234;
    @(negedge clk); bif.start = 1'b1;
    @(negedge clk); bif.start = 1'b0;
    sft_seen = 0;
    for (int i = 0; i < 100 && sft_seen < 5; i++) begin
      @(negedge clk);
      if (bif.sft) sft_seen++;
    end
    chk("fifth_shift_reached", 64'(sft_seen), 64'd5);
    #2 reset_n = 1'b0;
    #1 chk("async_reset_outs", 64'(outs), 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run_op(16'd3, 16'd5, 32'h0000_000F, 39, 4, 1'b0);
    @(negedge clk);

`ifdef BOOTH_CTRL_ABORT_EN
    din_m = 16'd7; din_q = 16'hFFFD;
    @(negedge clk); bif.start = 1'b1;
    @(negedge clk); bif.start = 1'b0;
    for (int i = 0; i < 20 && !bif.ld_a; i++) @(negedge clk);
    chk("arith_reached", 64'(bif.ld_a), 64'd1);
    bif.abort = 1'b1;
    #1;
    chk("abort_clr_a", 64'(bif.clr_a), 64'd1);
    chk("abort_clr_qm1", 64'(bif.clr_qm1), 64'd1);
    @(posedge clk); #1;
    bif.abort = 1'b0;
    chk("abort_idle", 64'(outs), 64'd0);
    done_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bif.done) done_seen++;
    end
    chk("abort_no_done", 64'(done_seen), 64'd0);
`else
    done_seen = 0;
`endif

    chk("strobe_overlap", 64'(overlap), 64'd0);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/booth_ctrl.md
# booth_ctrl

Control FSM for the radix-2 Booth multiplier. Sequences operand loading, the add/subtract/arithmetic-shift iterations and completion handshake for the multiplier datapath. Drives the datapath's iteration down-counter (load/decrement) and observes its zero flag. Sits between the top-level start/done interface and the A/Q/M/Q₋₁ registers and adder/subtractor.

## Interface
Parameters:
- N_BITS, 16, operand width; equals the number of Booth iterations.
- COUNT_WIDTH, 5, iteration-counter width; must satisfy 2^COUNT_WIDTH > N_BITS.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset; one clock, no other reset
- start  in  1  request; level, sampled in IDLE and DONE
- q0  in  1  LSB of Q register
- qm1  in  1  Q₋₁ flip-flop
- count_zero  in  1  iteration counter equals 0
- ld_m  out  1  load M from data_in bus
- ld_q  out  1  load Q from data_in bus
- clr_a  out  1  clear A
- clr_qm1  out  1  clear Q₋₁
- count_en  out  1  load iteration counter with N_BITS
- ld_a  out  1  load A with adder/subtractor result
- sel_sub  out  1  1 = A−M, 0 = A+M (meaningful only with ld_a)
- sft  out  1  arithmetic right shift of {A,Q,Q₋₁}
- decr  out  1  decrement iteration counter
- busy  out  1  operation in progress
- done  out  1  product valid in {A,Q}

## Operation
- States: IDLE, LOAD_M, LOAD_Q, EVAL, ARITH, SHIFT, DONE. Moore outputs, decoded from state register only.
- IDLE: all outputs 0. start=1 → LOAD_M.
- LOAD_M: ld_m=1, busy=1 → LOAD_Q.
- LOAD_Q: ld_q=1, clr_a=1, clr_qm1=1, count_en=1, busy=1 → EVAL.
- EVAL: busy=1. count_zero=1 → DONE. Else {q0,qm1}=10 or 01 → ARITH; 00 or 11 → SHIFT.
- ARITH: ld_a=1, busy=1, sel_sub = q0 & ~qm1 (10 → subtract, 01 → add) → SHIFT. The pair is stable because Q/Q₋₁ do not change in EVAL/ARITH.
- SHIFT: sft=1, decr=1, busy=1 → EVAL.
- DONE: done=1, busy=0. start=0 → IDLE; start=1 holds DONE (no restart until start drops).
- start during busy states ignored.
- Illegal state encodings → IDLE.

## Timing
- Reset: asynchronous to IDLE; every output 0 immediately, independent of clk.
- Reset mid-operation: operation discarded; after release, next start begins fresh from LOAD_M.
- Counter is loaded at the LOAD_Q edge; count_zero examined in EVAL one cycle after each SHIFT edge; exactly N_BITS SHIFT cycles per operation.
- Latency, start sampled in IDLE to first DONE cycle: 3 + N_BITS×2 + K cycles, K = number of ARITH iterations (0..N_BITS). N_BITS=16: 35 min, 51 max.
- done first asserted the cycle after the final EVAL; held while start=1.
- ld_a and sft never asserted in the same cycle; count_en and decr never in the same cycle.

## Configuration
- BOOTH_CTRL_ABORT_EN defined: extra input port abort (1 bit). abort=1 in any state except IDLE → IDLE on the next edge, with clr_a=1 and clr_qm1=1 asserted during that abort cycle (combinational on abort). done not asserted. abort has priority over every other transition, including DONE hold.
- Undefined: no abort port; behaviour exactly as above.

## Structure
- Shared package booth_pkg: state encoding constants (3-bit, IDLE=0), default N_BITS and COUNT_WIDTH.
- Single module, no sub-module: next-state logic and output decode in one block. Iteration counter and registers live in the datapath, not here.

## Test plan
Bench models datapath and counter behaviourally.
- Reset: reset_n=0 with clk stopped → all outputs 0, state IDLE; release, no start → outputs stay 0.
- M=5, Q=0 (all pairs 00): start pulse → 16 SHIFT, zero ld_a, done in cycle 35; product 0.
- M=7, Q=0xFFFD (−3): → first iteration sub, product 0xFFFFFFEB (−21); 51 ≥ latency ≥ 35, matches formula for K counted.
- M=0x8000, Q=0x8000: → product 0x40000000; decr count exactly 16; done held while start=1, IDLE one cycle after start=0.
- reset_n low during 5th SHIFT → outputs 0 asynchronously; restart with M=3, Q=5 → product 15.
- With BOOTH_CTRL_ABORT_EN: abort=1 in ARITH → clr_a=1, clr_qm1=1 that cycle, IDLE next, done never asserted.
